branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EXEC-side counterpart of branch_predictor.
- Carries each fetched instruction's prediction (valid + predicted target) from FETCH through DECODE into EXEC.
- Compares the prediction with the actual branch outcome from the ALU.
- Drives taken/not-taken feedback back into branch_predictor (x_predict_res) and issues a fetch redirect plus wrong-path squash on mispredict.

Parameters:
- ADDR_W, 32, PC/target width.
- FLUSH_CYCLES, 2, cycles of FETCH input ignored after a redirect (fetch refill latency); legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; freezes internal stage records.
- f_valid  in  1  FETCH delivered an instruction this cycle.
- f_pc  in  ADDR_W  PC of the fetched instruction.
- f_predict_valid  in  1  predictor hit for f_pc.
- f_predict_addr  in  ADDR_W  predicted target for f_pc.
- x_is_branch  in  1  EXEC-stage instruction is a branch; qualified by internal X record valid.
- x_taken  in  1  actual branch outcome.
- x_target  in  ADDR_W  actual branch target.
- x_res_valid  out  1  feedback strobe to predictor.
- x_predict_res  out  1  actual outcome (1 = taken) for x_res_pc.
- x_res_pc  out  ADDR_W  PC of the resolved branch.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  ADDR_W  correct next PC.
- flushing  out  1  high while in FLUSH state.

Behaviour:
- Reset: all outputs 0; D/X records invalid; state RUN; flush counter 0.
- Stage records {valid, pc, pred_valid, pred_addr}.
  - Each edge with !stall: X<=D, D<=F-capture.
  - F-capture valid = f_valid & (state==RUN).
  - With stall: both records hold; no resolution is produced (outputs drop to 0 next edge).
- Resolution, evaluated when X.valid & !stall, registered; outputs visible the edge after X evaluation (latency 1):
  - Branch, pred_valid=0, taken=0: correct. x_res_valid=1, x_predict_res=0.
  - Branch, pred_valid=0, taken=1: mispredict, redirect to x_target.
  - Branch, pred_valid=1, taken=0: mispredict, redirect to pc+4.
  - Branch, pred_valid=1, taken=1, pred_addr==x_target: correct.
  - Branch, pred_valid=1, taken=1, pred_addr!=x_target: mispredict, redirect to x_target.
  - Non-branch, pred_valid=1 (alias hit): redirect to pc+4. x_res_valid stays 0.
  - Non-branch, pred_valid=0: nothing.
  - Every branch asserts x_res_valid=1 with x_predict_res=x_taken, x_res_pc=X.pc, whether or not it mispredicted.
- pc+4 is computed modulo 2^ADDR_W (0xFFFFFFFC -> 0x0).
- FSM:
  - RUN: a mispredict goes to FLUSH. Same edge: clear D.valid and X.valid (mispredict/flush has priority over stall); load counter=FLUSH_CYCLES.
  - FLUSH: f_valid is ignored. Counter decrements every cycle, independent of stall. Return to RUN on the edge where the counter reaches 0. flushing=1 throughout.
  - No resolution can occur in FLUSH, since X is invalid.
- redirect_valid is a single-cycle pulse; redirect_pc is held until the next redirect.
- rst mid-FLUSH: immediate return to RUN; records cleared; pending outputs dropped.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each x_res_valid.
  - stat_mispredicts increments on each redirect_valid.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package bru_pkg:
  - bru_state_t {RUN, FLUSH}.
  - bru_rec_t record struct.
  - PC_INC = 4.
  - FLUSH_CNT_W = 3.
- Sub-module bru_stage_reg: one record register with stall hold and synchronous kill. Instantiated twice (D, X).

Test Plan:
- Correct not-taken: pc 0x1008, pred_valid=0, branch, taken=0 -> x_res_valid=1, x_predict_res=0, x_res_pc=0x1008, no redirect.
- Cold taken: pc 0x100c, pred_valid=0, taken=1, target 0x1014 -> redirect_valid pulse, redirect_pc=0x1014, flushing=1 for 2 cycles, next two f_valid ignored.
- Correct hit: pc 0x1014, pred 0x1000, taken=1, target 0x1000 -> x_predict_res=1, no redirect.
- Wrong target: pc 0x1014, pred 0x1010, taken=1, target 0x1000 -> redirect_pc=0x1000.
- Predicted taken but not taken: pc 0x1014, pred 0x1000, taken=0 -> redirect_pc=0x1018.
- Alias on non-branch: pc 0xFFFFFFFC, pred_valid=1, x_is_branch=0 -> redirect_pc=0x0, x_res_valid=0.
- Stall hold: stall held 3 cycles with a branch in X -> no outputs until released, then exactly one resolution.
- Reset mid-FLUSH: rst asserted mid-FLUSH -> flushing=0 next edge; records cleared.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit.
// Stage record, FSM state and fixed constants.
package bru_pkg;

  localparam int REC_AW      = 32;
  localparam int PC_INC      = 4;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic {
    RUN,
    FLUSH
  } bru_state_t;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] pc;
    logic              pred_valid;
    logic [REC_AW-1:0] pred_addr;
  } bru_rec_t;

endpackage

// File: rtl/bru_stage_reg.sv
// One prediction record register with stall hold
// and synchronous kill of the whole record.
module bru_stage_reg
  import bru_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     kill,
  input  bru_rec_t d,
  output bru_rec_t q
);

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EXEC branches against fetch predictions; redirects on miss.
// Optional BRU_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int ADDR_W       = REC_AW,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_predict_valid,
  input  logic [ADDR_W-1:0] f_predict_addr,
  input  logic              x_is_branch,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target,
  output logic              x_res_valid,
  output logic              x_predict_res,
  output logic [ADDR_W-1:0] x_res_pc,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flushing
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  bru_state_t           state;
  logic [FLUSH_CNT_W-1:0] cnt;
  bru_rec_t             f_rec, d_rec, x_rec;
  logic                 eval, mis, mispredict;
  logic [ADDR_W-1:0]    pc4, tgt;

  always_comb begin
    f_rec.valid      = f_valid & (state == RUN);
    f_rec.pc         = f_pc;
    f_rec.pred_valid = f_predict_valid;
    f_rec.pred_addr  = f_predict_addr;
  end

  bru_stage_reg u_d (
    .clk  (clk),
    .rst  (rst),
    .hold (stall),
    .kill (mispredict),
    .d    (f_rec),
    .q    (d_rec)
  );

  bru_stage_reg u_x (
    .clk  (clk),
    .rst  (rst),
    .hold (stall),
    .kill (mispredict),
    .d    (d_rec),
    .q    (x_rec)
  );

  assign eval = x_rec.valid & ~stall;
  assign pc4  = x_rec.pc + ADDR_W'(PC_INC);

  always_comb begin
    mis = 1'b0;
    tgt = x_target;
    unique case (1'b1)
      x_is_branch && x_taken: begin
        mis = !x_rec.pred_valid || (x_rec.pred_addr != x_target);
        tgt = x_target;
      end
      x_rec.pred_valid && !(x_is_branch && x_taken): begin
        mis = 1'b1;
        tgt = pc4;
      end
      default: ;
    endcase
  end

  assign mispredict = eval & mis;
  assign flushing   = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      cnt            <= '0;
      x_res_valid    <= 1'b0;
      x_predict_res  <= 1'b0;
      x_res_pc       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      x_res_valid    <= eval & x_is_branch;
      x_predict_res  <= eval & x_is_branch & x_taken;
      x_res_pc       <= (eval & x_is_branch) ? x_rec.pc : '0;
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= tgt;
      unique case (state)
        RUN: begin
          if (mispredict) begin
            state <= FLUSH;
            cnt   <= FLUSH_CNT_W'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          // fetch refill window runs regardless of stall
          cnt <= cnt - FLUSH_CNT_W'(1);
          if (cnt == FLUSH_CNT_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (x_res_valid && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (redirect_valid && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, stall, f_valid, f_predict_valid;
  logic [31:0] f_pc, f_predict_addr, x_target;
  logic        x_is_branch, x_taken;
  logic        x_res_valid, x_predict_res, redirect_valid, flushing;
  logic [31:0] x_res_pc, redirect_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .f_valid         (f_valid),
    .f_pc            (f_pc),
    .f_predict_valid (f_predict_valid),
    .f_predict_addr  (f_predict_addr),
    .x_is_branch     (x_is_branch),
    .x_taken         (x_taken),
    .x_target        (x_target),
    .x_res_valid     (x_res_valid),
    .x_predict_res   (x_predict_res),
    .x_res_pc        (x_res_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flushing        (flushing)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_x();
    x_is_branch = 1'b0;
    x_taken     = 1'b0;
    x_target    = '0;
  endtask

  task automatic idle(input int n);
    clr_x();
    f_valid = 1'b0;
    repeat (n) step();
  endtask

  // F -> D -> X, then resolve; returns just after the resolving edge
  task automatic run_br(input logic [31:0] pc, input logic pv,
                        input logic [31:0] pa, input logic br,
                        input logic tk, input logic [31:0] tgt);
    f_valid         = 1'b1;
    f_pc            = pc;
    f_predict_valid = pv;
    f_predict_addr  = pa;
    step();
    f_valid         = 1'b0;
    f_predict_valid = 1'b0;
    step();
    x_is_branch = br;
    x_taken     = tk;
    x_target    = tgt;
    step();
  endtask

  task automatic chk_res(input string tag, input logic rv, input logic pr,
                         input logic [31:0] rpc, input logic dv,
                         input logic [31:0] dpc, input logic fl);
    check({tag, ".res_valid"}, 32'(x_res_valid), 32'(rv));
    check({tag, ".pred_res"}, 32'(x_predict_res), 32'(pr));
    check({tag, ".res_pc"}, x_res_pc, rpc);
    check({tag, ".redir"}, 32'(redirect_valid), 32'(dv));
    check({tag, ".redir_pc"}, redirect_pc, dpc);
    check({tag, ".flushing"}, 32'(flushing), 32'(fl));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; f_valid = 1'b0; f_pc = '0;
    f_predict_valid = 1'b0; f_predict_addr = '0;
    clr_x();
    repeat (2) step();
    rst = 1'b0;
    chk_res("reset", 0, 0, 32'h0, 0, 32'h0, 0);

    run_br(32'h1008, 0, 32'h0, 1, 0, 32'h0);
    chk_res("nt_ok", 1, 0, 32'h1008, 0, 32'h0, 0);
    idle(1);
    check("nt_ok.pulse", 32'(x_res_valid), 32'h0);

    run_br(32'h100c, 0, 32'h0, 1, 1, 32'h1014);
    chk_res("cold", 1, 1, 32'h100c, 1, 32'h1014, 1);
    f_valid = 1'b1; f_pc = 32'h2000;
    step();
    check("cold.redir_drop", 32'(redirect_valid), 32'h0);
    check("cold.flush1", 32'(flushing), 32'h1);
    step();
    check("cold.flush_end", 32'(flushing), 32'h0);
    f_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("cold.ignored", 32'(x_res_valid), 32'h0);
      check("cold.no_redir", 32'(redirect_valid), 32'h0);
    end
    idle(1);

    run_br(32'h1014, 1, 32'h1000, 1, 1, 32'h1000);
    chk_res("hit", 1, 1, 32'h1014, 0, 32'h1014, 0);
    idle(1);

    run_br(32'h1014, 1, 32'h1010, 1, 1, 32'h1000);
    chk_res("bad_tgt", 1, 1, 32'h1014, 1, 32'h1000, 1);
    idle(3);

    run_br(32'h1014, 1, 32'h1000, 1, 0, 32'h0);
    chk_res("pt_nt", 1, 0, 32'h1014, 1, 32'h1018, 1);
    idle(3);

    run_br(32'hFFFFFFFC, 1, 32'h1234, 0, 0, 32'h0);
    chk_res("alias", 0, 0, 32'h0, 1, 32'h0, 1);
    idle(3);

    f_valid = 1'b1; f_pc = 32'h1020; f_predict_valid = 1'b0;
    step();
    f_valid = 1'b0;
    step();
    x_is_branch = 1'b1; x_taken = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.hold", 32'(x_res_valid), 32'h0);
    end
    stall = 1'b0;
    step();
    check("stall.res", 32'(x_res_valid), 32'h1);
    check("stall.res_pc", x_res_pc, 32'h1020);
    step();
    check("stall.once", 32'(x_res_valid), 32'h0);
    idle(1);

    run_br(32'h1040, 0, 32'h0, 1, 1, 32'h1080);
    check("rstfl.flushing", 32'(flushing), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_res("rstfl", 0, 0, 32'h0, 0, 32'h0, 0);
    x_is_branch = 1'b1; x_taken = 1'b1; x_target = 32'h5000;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rstfl.cleared", 32'(x_res_valid), 32'h0);
      check("rstfl.no_redir", 32'(redirect_valid), 32'h0);
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
